// File: rtl/mole_game_pkg.sv
// Shared state encoding, LFSR taps and arithmetic helpers for the mole game engine.
package mole_game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10
  } game_state_e;

  // Taps 16,14,13,11 on a right-shifting Fibonacci register: feedback enters at bit 15
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic int clog2_min1(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) bits = i + 1;
    end
    return (bits < 1) ? 1 : bits;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/mole_game_core_slot.sv
// One mole channel: lit flag plus an age counter that advances on game ticks.
module mole_slot
  import mole_game_pkg::*;
#(
  parameter int MOLE_LIFE = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic spawn_en,
  input  logic hit,
  input  logic clear_all,
  output logic lit,
  output logic expire
);

  localparam int AGE_W = clog2_min1(MOLE_LIFE);
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(MOLE_LIFE - 1);

  logic             lit_d, lit_q;
  logic [AGE_W-1:0] age_d, age_q;

  // A hit in the expiry cycle suppresses the expiry so it scores as a hit only
  assign expire = tick & lit_q & ~hit & (age_q == AGE_LAST);
  assign lit    = lit_q;

  always_comb begin
    lit_d = lit_q;
    age_d = age_q;
    if (clear_all || hit || expire) begin
      lit_d = 1'b0;
      age_d = '0;
    end else if (spawn_en && !lit_q) begin
      lit_d = 1'b1;
      age_d = '0;
    end else if (tick && lit_q) begin
      age_d = age_q + AGE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lit_q <= 1'b0;
      age_q <= '0;
    end else begin
      lit_q <= lit_d;
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/mole_game_core.sv
// Whack-a-mole round engine: tick divider, LFSR spawner, IDLE/PLAY/OVER control and scoring.
module mole_game_core
  import mole_game_pkg::*;
#(
  parameter int          N_MOLES    = 8,
  parameter int          TICK_DIV   = 250000,
  parameter int          MOLE_LIFE  = 6,
  parameter int          SPAWN_GAP  = 2,
  parameter int          GAME_TICKS = 120,
  parameter int          SCORE_W    = 10,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_MOLES-1:0] sw,
  output logic [N_MOLES-1:0] mole,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] misses,
  output logic [SCORE_W-1:0] penalties,
  output logic [15:0]        time_left,
  output logic [1:0]         state,
  output logic               tick
);

  localparam int               IDX_W      = clog2_min1(N_MOLES);
  localparam int               DIV_W      = clog2_min1(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [7:0]       GAP_LAST   = 8'(SPAWN_GAP - 1);
  localparam logic [15:0]      ROUND_LEN  = 16'(GAME_TICKS);
  localparam logic [31:0]      SAT_MAX    = (32'd1 << SCORE_W) - 32'd1;

  game_state_e        state_d, state_q;
  logic [DIV_W-1:0]   div_d, div_q;
  logic               tick_d, tick_q;
  logic [15:0]        lfsr_d, lfsr_q;
  logic [N_MOLES-1:0] sw_q;
  logic [N_MOLES-1:0] toggle_d, toggle_q;
  logic [7:0]         gap_d, gap_q;
  logic [15:0]        time_d, time_q;
  logic [SCORE_W-1:0] score_d, score_q;
  logic [SCORE_W-1:0] misses_d, misses_q;
  logic [SCORE_W-1:0] pen_d, pen_q;

  logic [N_MOLES-1:0] lit, expire, hit, pen_mask, spawn_en;
  logic               in_play, round_end, clear_all, spawn_try;
  logic [IDX_W-1:0]   spawn_idx;
  logic [31:0]        hit_cnt, miss_cnt, pen_cnt;

  // Free-running pacing: divider, tick pulse aligned with the divider's last count, LFSR
  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    tick_d   = (div_d == DIV_LAST);
    lfsr_d   = lfsr_next(lfsr_q);
    toggle_d = sw ^ sw_q;
  end

  assign in_play   = (state_q == ST_PLAY);
  assign hit       = toggle_q & lit & {N_MOLES{in_play}};
  assign pen_mask  = toggle_q & ~lit & {N_MOLES{in_play}};
  assign round_end = in_play & tick_q & (time_q == 16'd1);
  assign spawn_try = in_play & tick_q & (gap_q == GAP_LAST) & ~round_end;
  assign spawn_idx = lfsr_q[IDX_W-1:0];
  assign clear_all = ~in_play | round_end;

  for (genvar i = 0; i < N_MOLES; i++) begin : g_slot
    assign spawn_en[i] = spawn_try & (spawn_idx == IDX_W'(i));

    mole_slot #(
      .MOLE_LIFE(MOLE_LIFE)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick_q),
      .spawn_en (spawn_en[i]),
      .hit      (hit[i]),
      .clear_all(clear_all),
      .lit      (lit[i]),
      .expire   (expire[i])
    );
  end

  always_comb begin
    hit_cnt  = '0;
    miss_cnt = '0;
    pen_cnt  = '0;
    for (int i = 0; i < N_MOLES; i++) begin
      hit_cnt  = hit_cnt + 32'(hit[i]);
      miss_cnt = miss_cnt + 32'(expire[i]);
      pen_cnt  = pen_cnt + 32'(pen_mask[i]);
    end
  end

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    time_d   = time_q;
    score_d  = score_q;
    misses_d = misses_q;
    pen_d    = pen_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d  = ST_PLAY;
          gap_d    = '0;
          time_d   = ROUND_LEN;
          score_d  = '0;
          misses_d = '0;
          pen_d    = '0;
        end
      end
      ST_PLAY: begin
        score_d  = SCORE_W'(sat_add(32'(score_q), hit_cnt, SAT_MAX));
        misses_d = SCORE_W'(sat_add(32'(misses_q), miss_cnt, SAT_MAX));
        pen_d    = SCORE_W'(sat_add(32'(pen_q), pen_cnt, SAT_MAX));
        if (tick_q) begin
          gap_d  = (gap_q == GAP_LAST) ? '0 : gap_q + 8'd1;
          time_d = time_q - 16'd1;
          if (round_end) state_d = ST_OVER;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      tick_q   <= 1'b0;
      lfsr_q   <= LFSR_SEED;
      sw_q     <= sw;
      toggle_q <= '0;
      gap_q    <= '0;
      time_q   <= ROUND_LEN;
      score_q  <= '0;
      misses_q <= '0;
      pen_q    <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      lfsr_q   <= lfsr_d;
      sw_q     <= sw;
      toggle_q <= toggle_d;
      gap_q    <= gap_d;
      time_q   <= time_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      pen_q    <= pen_d;
    end
  end

  assign mole      = lit;
  assign score     = score_q;
  assign misses    = misses_q;
  assign penalties = pen_q;
  assign time_left = time_q;
  assign state     = state_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_mole_game_core.sv
// Directed plus randomized bench for mole_game_core against a cycle-level behavioural game model.
`timescale 1ns/1ps
module tb_mole_game_core;

  localparam int NM   = 8;
  localparam int TD   = 4;
  localparam int LIFE = 3;
  localparam int GAP  = 1;
  localparam int GT   = 10;
  localparam int SW_W = 3;
  localparam int SAT  = 7;
  localparam int SEED = 16'hACE1;

  logic            clk;
  logic            rst;
  logic            start;
  logic [NM-1:0]   sw;
  logic [NM-1:0]   mole;
  logic [SW_W-1:0] score;
  logic [SW_W-1:0] misses;
  logic [SW_W-1:0] penalties;
  logic [15:0]     time_left;
  logic [1:0]      state;
  logic            tick;

  int total = 0;
  int bad   = 0;
  string phase = "init";

  int          m_state, m_score, m_miss, m_pen, m_time, m_div, m_gap, m_lfsr;
  bit          m_tick;
  bit [NM-1:0] m_mole, m_swq, m_tgl;
  int          m_age[NM];

  mole_game_core #(
    .N_MOLES   (NM),
    .TICK_DIV  (TD),
    .MOLE_LIFE (LIFE),
    .SPAWN_GAP (GAP),
    .GAME_TICKS(GT),
    .SCORE_W   (SW_W),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sw       (sw),
    .mole     (mole),
    .score    (score),
    .misses   (misses),
    .penalties(penalties),
    .time_left(time_left),
    .state    (state),
    .tick     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lfsrStep(input int v);
    int fb;
    fb = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return (v >> 1) | (fb << 15);
  endfunction

  function automatic int satAdd(input int a, input int b);
    return (a + b > SAT) ? SAT : a + b;
  endfunction

  // Game rules applied once per clock edge, using the values seen just before the edge
  task automatic modelStep();
    bit [NM-1:0] next_lit;
    int hits, pens, exps, k;
    bit ending;
    if (rst !== 1'b1) begin
      m_state = 0; m_mole = '0; m_score = 0; m_miss = 0; m_pen = 0;
      m_time = GT; m_div = 0; m_tick = 0; m_lfsr = SEED; m_swq = sw; m_tgl = '0; m_gap = 0;
      foreach (m_age[i]) m_age[i] = 0;
      return;
    end
    if (m_state == 1) begin
      hits = 0; pens = 0; exps = 0; ending = 0; next_lit = m_mole;
      for (int i = 0; i < NM; i++) begin
        if (m_tgl[i]) begin
          if (m_mole[i]) begin hits++; next_lit[i] = 1'b0; end
          else pens++;
        end
      end
      if (m_tick) begin
        for (int i = 0; i < NM; i++) begin
          if (next_lit[i]) begin
            if (m_age[i] == LIFE - 1) begin exps++; next_lit[i] = 1'b0; end
            else m_age[i]++;
          end
        end
        m_time--;
        ending = (m_time == 0);
        if (m_gap == GAP - 1) begin
          m_gap = 0;
          k = m_lfsr % NM;
          if (!ending && !m_mole[k]) begin next_lit[k] = 1'b1; m_age[k] = 0; end
        end else begin
          m_gap++;
        end
      end
      if (ending) begin next_lit = '0; m_state = 2; end
      m_mole  = next_lit;
      m_score = satAdd(m_score, hits);
      m_miss  = satAdd(m_miss, exps);
      m_pen   = satAdd(m_pen, pens);
    end else if (start) begin
      m_state = 1; m_score = 0; m_miss = 0; m_pen = 0; m_time = GT; m_gap = 0;
    end
    m_div  = (m_div + 1) % TD;
    m_tick = (m_div == TD - 1);
    m_lfsr = lfsrStep(m_lfsr);
    m_tgl  = sw ^ m_swq;
    m_swq  = sw;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic boundCheck(input string tag, input bit reached);
    total++;
    assert (reached) else begin
      bad++;
      $error("[TB] FAIL %s: observed=timeout expected=reached", tag);
    end
  endtask

  task automatic checkAll();
    checkOutput({phase, ".mole"},      32'(mole),      32'(m_mole));
    checkOutput({phase, ".score"},     32'(score),     32'(m_score));
    checkOutput({phase, ".misses"},    32'(misses),    32'(m_miss));
    checkOutput({phase, ".penalties"}, 32'(penalties), 32'(m_pen));
    checkOutput({phase, ".time_left"}, 32'(time_left), 32'(m_time));
    checkOutput({phase, ".state"},     32'(state),     32'(m_state));
    checkOutput({phase, ".tick"},      32'(tick),      32'(m_tick));
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic [NM-1:0] w);
    rst = r; start = s; sw = w;
    modelStep();
    @(posedge clk);
    #1;
    checkAll();
  endtask

  initial begin
    int k;
    bit found;
    logic [NM-1:0] w;
    rst = 1'b0; start = 1'b0; sw = '1;

    phase = "reset";
    repeat (3) applyStimulus(1'b0, 1'b0, 8'hFF);
    checkOutput("reset.state_idle", 32'(state), 32'd0);
    checkOutput("reset.mole_dark", 32'(mole), 32'd0);
    checkOutput("reset.time_left", 32'(time_left), 32'd10);
    phase = "release";
    repeat (3) applyStimulus(1'b1, 1'b0, 8'hFF);
    checkOutput("release.no_penalty", 32'(penalties), 32'd0);

    // Untouched round: moles spawn on ticks and expire as misses
    phase = "spawn";
    applyStimulus(1'b1, 1'b1, sw);
    for (int c = 0; c < 100 && m_state != 2; c++) applyStimulus(1'b1, 1'b0, sw);
    boundCheck("spawn.round_end", m_state == 2);
    checkOutput("spawn.over_state", 32'(state), 32'd2);
    checkOutput("spawn.over_mole", 32'(mole), 32'd0);
    checkOutput("spawn.over_time", 32'(time_left), 32'd0);
    checkOutput("spawn.score_zero", 32'(score), 32'd0);

    phase = "hit";
    applyStimulus(1'b1, 1'b1, sw);
    for (int c = 0; c < 60 && !(m_mole != 0 && !m_tick && m_time >= 8); c++) applyStimulus(1'b1, 1'b0, sw);
    boundCheck("hit.mole_lit", m_mole != 0);
    k = 0;
    for (int i = NM - 1; i >= 0; i--) if (m_mole[i]) k = i;
    w = sw; w[k] = ~w[k];
    applyStimulus(1'b1, 1'b0, w);
    applyStimulus(1'b1, 1'b0, w);
    checkOutput("hit.score_one", 32'(score), 32'd1);
    checkOutput("hit.mole_cleared", 32'(mole[k]), 32'd0);
    for (int c = 0; c < 40 && (m_tick || m_mole[k]); c++) applyStimulus(1'b1, 1'b0, sw);
    w = sw; w[k] = ~w[k];
    found = (m_state == 1) && !m_mole[k] && !m_tick;
    applyStimulus(1'b1, 1'b0, w);
    applyStimulus(1'b1, 1'b0, w);
    if (found) checkOutput("hit.penalty_one", 32'(penalties), 32'd1);
    for (int c = 0; c < 100 && m_state != 2; c++) applyStimulus(1'b1, 1'b0, sw);

    phase = "all_toggle";
    applyStimulus(1'b1, 1'b1, sw);
    for (int c = 0; c < 60 && !($countones(m_mole) >= 3 && !m_tick && m_time > 1); c++)
      applyStimulus(1'b1, 1'b0, sw);
    found = ($countones(m_mole) >= 3) && !m_tick && (m_time > 1) && (m_state == 1);
    applyStimulus(1'b1, 1'b0, ~sw);
    applyStimulus(1'b1, 1'b0, sw);
    if (found) begin
      checkOutput("all_toggle.score_three", 32'(score), 32'd3);
      checkOutput("all_toggle.penalty_five", 32'(penalties), 32'd5);
    end
    for (int c = 0; c < 100 && m_state != 2; c++) applyStimulus(1'b1, 1'b0, sw);

    // Toggle timed so its effect lands on the tick where the mole would expire
    phase = "expiry_hit";
    applyStimulus(1'b1, 1'b1, sw);
    found = 1'b0;
    k = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      for (int i = 0; i < NM; i++) begin
        if (!found && m_state == 1 && m_div == TD - 2 && m_time > 1 && m_mole[i] && m_age[i] == LIFE - 1) begin
          found = 1'b1; k = i;
        end
      end
      if (!found) applyStimulus(1'b1, 1'b0, sw);
    end
    boundCheck("expiry_hit.found", found);
    w = sw; w[k] = ~w[k];
    applyStimulus(1'b1, 1'b0, w);
    applyStimulus(1'b1, 1'b0, w);
    if (found) checkOutput("expiry_hit.score_one", 32'(score), 32'd1);
    for (int c = 0; c < 100 && m_state != 2; c++) applyStimulus(1'b1, 1'b0, sw);

    phase = "saturate";
    applyStimulus(1'b1, 1'b1, sw);
    for (int c = 0; c < 100 && m_state != 2; c++) applyStimulus(1'b1, 1'b0, sw ^ m_mole);
    boundCheck("saturate.round_end", m_state == 2);
    checkOutput("saturate.score_stuck", 32'(score), 32'd7);
    checkOutput("saturate.penalty_stuck", 32'(penalties), 32'd7);

    phase = "restart";
    applyStimulus(1'b1, 1'b1, sw);
    checkOutput("restart.state_play", 32'(state), 32'd1);
    checkOutput("restart.score_clear", 32'(score), 32'd0);
    checkOutput("restart.penalty_clear", 32'(penalties), 32'd0);
    checkOutput("restart.time_left", 32'(time_left), 32'd10);
    phase = "start_held";
    for (int c = 0; c < 20; c++) applyStimulus(1'b1, 1'b1, sw ^ 8'($urandom));
    checkOutput("start_held.still_play", 32'(state), 32'd1);

    phase = "abort";
    applyStimulus(1'b0, 1'b0, sw);
    checkOutput("abort.state_idle", 32'(state), 32'd0);
    checkOutput("abort.score_clear", 32'(score), 32'd0);
    checkOutput("abort.misses_clear", 32'(misses), 32'd0);
    checkOutput("abort.mole_dark", 32'(mole), 32'd0);
    checkOutput("abort.time_left", 32'(time_left), 32'd10);
    applyStimulus(1'b1, 1'b0, sw);

    phase = "random";
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) w = sw ^ 8'($urandom);
      else w = sw ^ (m_mole & 8'($urandom));
      applyStimulus($urandom_range(0, 149) != 0, $urandom_range(0, 24) == 0, w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
